// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART with TX and RX engines sharing one clock.
// Baud timing comes from per-engine cycle counters, so there is no derived clock.
// Frame format (data width, parity, stop bits) is fixed at elaboration.
//
// Optional build macro: UART_LOOPBACK_EN adds the 'loopback' input. When it is
// high, RX listens to the internal TX line and the tx pin is held high.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active low
//   rx          serial input (asynchronous to clk)
//   loopback    internal TX->RX loop enable (UART_LOOPBACK_EN builds only)
//   dintx       TX payload
//   newd        TX request, only looked at while the transmitter is idle
//   tx          serial output, idle high
//   txbusy      TX frame in progress
//   donetx      one-cycle pulse during the final cycle of the stop period
//   doutrx      last received payload
//   donerx      one-cycle pulse when doutrx and the error flags update
//   parity_err  parity mismatch on the last frame (always 0 without parity)
//   frame_err   first stop bit of the last frame was sampled low
module uart_core_param #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic [DATA_BITS-1:0] dintx,
  input  logic                 newd,
  output logic                 tx,
  output logic                 txbusy,
  output logic                 donetx,
  output logic [DATA_BITS-1:0] doutrx,
  output logic                 donerx,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int STOP_LEN     = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(STOP_LEN);
  localparam int BIT_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam bit HAS_PARITY   = (PARITY != 0);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_LEN - 1);
  localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(STOP_LEN - 2);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Odd mode sends the inverse of the XOR so the total count of ones is odd.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  logic [2:0]           tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_int;

  logic                 rx_src;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_s_d;
  logic [2:0]           rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_int : rx;
  assign tx     = loopback ? 1'b1 : tx_int;
`else
  assign rx_src = rx;
  assign tx     = tx_int;
`endif

  // Transmitter. tx is registered and changes only at bit boundaries; the
  // payload is shifted right so the next bit to send is always bit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_int   <= 1'b1;
      txbusy   <= 1'b0;
      donetx   <= 1'b0;
    end else begin
      donetx <= 1'b0;
      case (tx_state)
        ST_IDLE: begin
          if (newd) begin
            tx_shift <= dintx;
            tx_par   <= calc_parity(dintx);
            tx_int   <= 1'b0;
            txbusy   <= 1'b1;
            tx_cnt   <= '0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_int   <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
              if (HAS_PARITY) begin
                tx_int   <= tx_par;
                tx_state <= ST_PARITY;
              end else begin
                tx_int   <= 1'b1;
                tx_state <= ST_STOP;
              end
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_int   <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_int   <= 1'b1;
            tx_state <= ST_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // donetx is raised one edge early so it is high in the final cycle.
          if (tx_cnt == STOP_END) begin
            tx_cnt   <= '0;
            txbusy   <= 1'b0;
            tx_state <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
            if (tx_cnt == DONE_AT) donetx <= 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // Receiver. After the start midpoint every later sample lands mid-bit.
  // Data enters at the MSB and shifts right, so LSB-first arrival ends aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state   <= ST_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par     <= 1'b0;
      doutrx     <= '0;
      donerx     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      donerx <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (rx_s_d && !rx_s) begin
            rx_cnt   <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) begin
              rx_state <= HAS_PARITY ? ST_PARITY : ST_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_par   <= rx_s;
            rx_state <= ST_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Only the first stop bit is checked; returning to IDLE at its
          // midpoint leaves time to catch a back-to-back start edge.
          if (rx_cnt == BIT_END) begin
            rx_cnt     <= '0;
            doutrx     <= rx_shift;
            parity_err <= HAS_PARITY && (rx_par != calc_parity(rx_shift));
            frame_err  <= ~rx_s;
            donerx     <= 1'b1;
            rx_state   <= ST_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised next-generation UART core: full-duplex TX and RX engines in one clock domain.
- Baud timing comes from cycle counters with enables; no derived UART clocks.
- Frame format is configurable at elaboration time: data width, parity mode and stop-bit count.
- RX reports parity and framing errors. Replaces uart_top as the unit instantiated under the UART environment bench.

Parameters:
- CLK_FREQ, 1000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer-truncated, must be >= 8.
- DATA_BITS, 8, payload width, legal values 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- rx  in  1  serial input, asynchronous to clk.
- dintx  in  DATA_BITS  TX payload.
- newd  in  1  TX request; sampled only when txbusy=0.
- tx  out  1  serial output, idle high.
- txbusy  out  1  TX frame in progress.
- donetx  out  1  one-cycle pulse at the end of the last stop bit.
- doutrx  out  DATA_BITS  last received payload.
- donerx  out  1  one-cycle pulse when doutrx and the error flags update.
- parity_err  out  1  parity mismatch on the last frame; always 0 when PARITY=0.
- frame_err  out  1  a stop bit was sampled low on the last frame.

Behaviour:
- Reset (rst=0 at a clk edge):
  - tx=1; txbusy, donetx, donerx, parity_err, frame_err = 0; doutrx = 0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset mid-frame aborts the frame immediately and produces no done pulse.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - Accept: newd=1 while in IDLE latches dintx and moves to START at the next edge. tx goes low and txbusy rises on that same edge.
  - Bit time: each bit holds exactly CLKS_PER_BIT cycles.
  - Bit order: data LSB first, bit index 0..DATA_BITS-1.
  - Parity bit: even mode sends XOR of the data bits; odd mode sends its inverse.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. In the final cycle of STOP, donetx=1.
  - Return to IDLE: txbusy falls on the next edge.
  - newd while txbusy=1, including the donetx cycle, is ignored and not queued.
  - Total frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- RX input conditioning: rx passes through a 2-flop synchroniser. Latency from rx to internal rx_s is 2 cycles.
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - IDLE: a falling edge on rx_s enters START.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If rx_s=1, treat as a glitch and return to IDLE with no pulse.
  - DATA, PARITY, STOP: sample rx_s every CLKS_PER_BIT cycles after the start midpoint.
  - Only the first stop bit is checked.
  - On the first stop-bit sample, update doutrx, parity_err and frame_err, and pulse donerx for 1 cycle, all on the same edge. Then return to IDLE.
  - A new start edge is accepted from the cycle after donerx. Back-to-back frames must not be lost.
- Error flags hold their value until the next donerx.
- TX and RX are fully independent; simultaneous activity is legal.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit).
  - loopback=1 feeds the RX synchroniser from internal tx instead of the rx pin.
  - The tx pin is forced high while loopback=1.
- When undefined: the port is absent and RX always uses the rx pin.

Test Plan:
- 8N1, CLKS_PER_BIT=104, newd with dintx=0xA5, tx looped to rx:
  - tx low for cycles 1..104 after accept, then bits 1,0,1,0,0,1,0,1.
  - donetx at cycle 1040.
  - donerx with doutrx=0xA5, both error flags 0.
- PARITY=2, send 0x07 -> parity bit 1; RX reports parity_err=0.
- PARITY=2, bench drives 0x07 with parity bit 0 -> donerx with doutrx=0x07, parity_err=1.
- Bench drives a frame for 0x3C with the stop bit low -> donerx, doutrx=0x3C, frame_err=1. A following good frame for 0x11 clears frame_err.
- newd pulsed at cycle 500 of a frame and again in the donetx cycle -> both ignored; only one frame is sent.
- Glitches and reset:
  - rx low for 20 cycles, then high -> no donerx.
  - rst=0 at cycle 300 of a TX frame -> next edge tx=1 and txbusy=0; no donetx ever follows.
